// File: rtl/alu_result_fifo.sv
// Result FIFO for a 4-bit ALU: buffers {detect, zero, sum} entries behind a registered
// read port and keeps saturating statistics on accepted and dropped results.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       IN_VALID,
    input  logic [3:0]                 IN_C,
    input  logic                       IN_ZERO,
    input  logic                       IN_DETECT,
    input  logic                       RD_EN,
    input  logic                       CLR_CNT,
    output logic [5:0]                 RD_DATA,
    output logic                       RD_VALID,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic [CNT_W-1:0]           ZERO_CNT,
    output logic [CNT_W-1:0]           DET_CNT,
    output logic [CNT_W-1:0]           DROP_CNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [5:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             rd_acc;
    logic             wr_acc;
    logic             drop;

    assign EMPTY = (level == '0);
    assign FULL  = (level == FULL_LEVEL);
    assign LEVEL = level;

    // A read frees the head slot this edge, so a full FIFO can still take a write.
    assign rd_acc = RD_EN && !EMPTY;
    assign wr_acc = IN_VALID && (!FULL || rd_acc);
    assign drop   = IN_VALID && !wr_acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + CNT_W'(1);
    endfunction

    // NOTE: storage has no reset; LEVEL/pointers going to zero make stale entries unreachable.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {IN_DETECT, IN_ZERO, IN_C};
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                RD_DATA <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                level <= level + LVL_W'(1);
            end else if (rd_acc && !wr_acc) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ZERO_CNT <= '0;
            DET_CNT  <= '0;
            DROP_CNT <= '0;
        end else if (CLR_CNT) begin
            ZERO_CNT <= '0;
            DET_CNT  <= '0;
            DROP_CNT <= '0;
        end else begin
            if (wr_acc && IN_ZERO) begin
                ZERO_CNT <= sat_inc(ZERO_CNT);
            end
            if (wr_acc && IN_DETECT) begin
                DET_CNT <= sat_inc(DET_CNT);
            end
            if (drop) begin
                DROP_CNT <= sat_inc(DROP_CNT);
            end
        end
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 Parameter CNT_W, default 8, width of statistics counters.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 IN_VALID  input  1  ALU result present this cycle.
REQ-006 IN_C  input  4  ALU sum.
REQ-007 IN_ZERO  input  1  ALU zero flag.
REQ-008 IN_DETECT  input  1  ALU overflow-pattern flag.
REQ-009 RD_EN  input  1  read request.
REQ-010 CLR_CNT  input  1  synchronous clear of statistics counters.
REQ-011 RD_DATA  output  6  entry {detect, zero, C[3:0]}; registered.
REQ-012 RD_VALID  output  1  RD_DATA holds a newly read entry this cycle.
REQ-013 EMPTY  output  1  no entries stored.
REQ-014 FULL  output  1  DEPTH entries stored.
REQ-015 LEVEL  output  log2(DEPTH)+1  stored entry count.
REQ-016 ZERO_CNT  output  CNT_W  accepted entries with zero flag set.
REQ-017 DET_CNT  output  CNT_W  accepted entries with detect flag set.
REQ-018 DROP_CNT  output  CNT_W  results rejected because FIFO full.

Function
REQ-019 Write accept SHALL occur when IN_VALID=1 and (FULL=0 or read accept in same cycle).
REQ-020 Read accept SHALL occur when RD_EN=1 and EMPTY=0; RD_EN on empty SHALL be ignored, no state change.
REQ-021 Accepted write SHALL store {IN_DETECT, IN_ZERO, IN_C} at write pointer; pointer SHALL wrap modulo DEPTH.
REQ-022 Read accept SHALL load head entry into RD_DATA and assert RD_VALID for exactly one cycle, one cycle after RD_EN edge (latency 1).
REQ-023 RD_DATA SHALL hold last read value when no read accept; RD_VALID=0 then.
REQ-024 Simultaneous read and write accept SHALL keep LEVEL unchanged; with FULL=1 both SHALL succeed.
REQ-025 Simultaneous read and write on EMPTY SHALL accept write only; no fall-through; RD_VALID=0.
REQ-026 LEVEL SHALL be +1 on write only, -1 on read only, unchanged otherwise; range 0..DEPTH.
REQ-027 EMPTY SHALL equal (LEVEL==0); FULL SHALL equal (LEVEL==DEPTH); both combinational from registered LEVEL.
REQ-028 ZERO_CNT/DET_CNT SHALL increment by 1 per accepted write with respective flag set.
REQ-029 DROP_CNT SHALL increment by 1 per IN_VALID=1 cycle not accepted.
REQ-030 All counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-031 CLR_CNT=1 SHALL zero all three counters next edge, overriding any same-cycle increment; FIFO contents unaffected.
REQ-032 Inputs SHALL be sampled at the same rising edge that registers the ALU result; IN_C is treated as already registered.

Reset
REQ-033 RST=0 SHALL immediately force: pointers 0, LEVEL 0, EMPTY 1, FULL 0, RD_DATA 0, RD_VALID 0, all counters 0.
REQ-034 RST asserted mid-operation SHALL discard all stored entries; no write or read accepted while RST=0.
REQ-035 Storage array contents need no reset; unread entries SHALL never be visible after reset.

Verification
REQ-036 Reset, then write C=7,Z=0,D=0; RD_EN next cycle -> RD_DATA=6'b000111, RD_VALID pulse 1 cycle, EMPTY=1 after.
REQ-037 Write 5 consecutive C=1..5 with no reads (DEPTH=4) -> FULL=1 after 4th, DROP_CNT=1, reads return 1,2,3,4 in order.
REQ-038 FULL with IN_VALID=1 and RD_EN=1 same cycle -> LEVEL stays 4, DROP_CNT unchanged, read returns oldest entry.
REQ-039 Write C=0,Z=1 and C=0,D=1,Z=1 -> ZERO_CNT=2, DET_CNT=1; assert CLR_CNT with a Z=1 write -> ZERO_CNT=0, entry still stored.
REQ-040 Drive 300 rejected writes while FULL -> DROP_CNT saturates at 255.
REQ-041 Pulse RST low with LEVEL=3 -> EMPTY=1, LEVEL=0, counters 0 immediately; subsequent read on empty gives RD_VALID=0.
